pipeline_hazard_unit: RTL and testbench

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

---
 rtl/pipeline_hazard_unit.sv | 120 ++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use/branch stalls,
// memory-wait freeze with timeout fault, and a saturating stall counter.
// Define HAZARD_FORWARDING_EN to enable forwarding; otherwise every EX/MEM match stalls.
module pipeline_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int WAIT_TO = 15,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_taken,
  input  logic              ex_wen,
  input  logic              mem_wen,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic              ex_is_load,
  input  logic              mem_is_load,
  input  logic              mem_access,
  input  logic              MIO_ready,
  output logic [1:0]        fwd_rs,
  output logic [1:0]        fwd_rt,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic              ifid_flush,
  output logic              mem_timeout,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam int WCW = (WAIT_TO < 1) ? 1 : $clog2(WAIT_TO + 1);
  localparam logic [WCW-1:0]    WAIT_LIM = WCW'(WAIT_TO);
  localparam logic [PERF_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {RUN, MWAIT, FAULT} state_t;

  state_t         stateQ, stateD;
  logic [WCW-1:0] waitCnt, waitCntD;
  logic           exRs, exRt, memRs, memRt;
  logic           dataStall, frozen;

  // Register x0 never carries a hazard, and unused sources cannot match.
  assign exRs  = ex_wen  && (ex_waddr  == id_rs) && (id_rs != '0) && id_use_rs;
  assign exRt  = ex_wen  && (ex_waddr  == id_rt) && (id_rt != '0) && id_use_rt;
  assign memRs = mem_wen && (mem_waddr == id_rs) && (id_rs != '0) && id_use_rs;
  assign memRt = mem_wen && (mem_waddr == id_rt) && (id_rt != '0) && id_use_rt;

`ifdef HAZARD_FORWARDING_EN
  // EX wins over MEM; an EX load has no data yet, so it selects the regfile and stalls.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    fwd_rs = 2'd0;
    fwd_rt = 2'd0;
    if (exRs)       fwd_rs = ex_is_load ? 2'd0 : 2'd1;
    else if (memRs) fwd_rs = mem_is_load ? 2'd3 : 2'd2;
    if (exRt)       fwd_rt = ex_is_load ? 2'd0 : 2'd1;
    else if (memRt) fwd_rt = mem_is_load ? 2'd3 : 2'd2;
  end

  assign dataStall = (ex_is_load && (exRs || exRt)) || (id_branch && (exRs || exRt));
`else
  logic unusedFwdInputs;

  assign unusedFwdInputs = ^{ex_is_load, mem_is_load, id_branch};
  assign fwd_rs    = 2'd0;
  assign fwd_rt    = 2'd0;
  assign dataStall = exRs || exRt || memRs || memRt;
`endif

  // The ready cycle completes the access, so MWAIT only freezes while the bus is busy.
  assign frozen = (stateQ == FAULT)
               || ((stateQ == MWAIT) && !MIO_ready)
               || (mem_access && !MIO_ready);

  assign pipe_freeze = frozen;
  assign pc_stall    = frozen || dataStall;
  assign ifid_stall  = frozen || dataStall;
  assign idex_bubble = dataStall && !frozen;
  assign ifid_flush  = id_taken && !dataStall && !frozen;
  assign mem_timeout = (stateQ == FAULT);

  always_comb begin
    stateD   = stateQ;
    waitCntD = waitCnt;
    case (stateQ)
      RUN: begin
        if (mem_access && !MIO_ready) begin
          stateD   = MWAIT;
          waitCntD = '0;
        end
      end
      MWAIT: begin
        if (MIO_ready)                stateD   = RUN;
        else if (waitCnt == WAIT_LIM) stateD   = FAULT;
        else                          waitCntD = waitCnt + 1'b1;
      end
      FAULT:   stateD = FAULT;
      default: stateD = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= RUN;
      waitCnt   <= '0;
      stall_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      stateQ  <= stateD;
      waitCnt <= waitCntD;
      if (pc_stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: directed vectors push expected outputs,
// a negedge monitor pops and compares. Expectations follow HAZARD_FORWARDING_EN.
module tb_pipeline_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int WAIT_TO = 15;
  localparam int PERF_W  = 4;
  localparam int CNT_MAX = 15;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] id_rs, id_rt, ex_waddr, mem_waddr;
  logic              id_use_rs, id_use_rt, id_branch, id_taken;
  logic              ex_wen, mem_wen, ex_is_load, mem_is_load, mem_access, MIO_ready;
  logic [1:0]        fwd_rs, fwd_rt;
  logic              pc_stall, ifid_stall, idex_bubble, pipe_freeze, ifid_flush, mem_timeout;
  logic [PERF_W-1:0] stall_cnt;

  pipeline_hazard_unit #(.REG_AW(REG_AW), .WAIT_TO(WAIT_TO), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_taken(id_taken),
    .ex_wen(ex_wen), .mem_wen(mem_wen), .ex_waddr(ex_waddr), .mem_waddr(mem_waddr),
    .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
    .mem_access(mem_access), .MIO_ready(MIO_ready),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .ifid_flush(ifid_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        fwdRs;
    logic [1:0]        fwdRt;
    logic              pcStall;
    logic              ifidStall;
    logic              idexBubble;
    logic              pipeFreeze;
    logic              ifidFlush;
    logic              memTimeout;
    logic [PERF_W-1:0] stallCnt;
  } out_t;

  typedef struct {
    out_t  exp;
    string name;
  } item_t;

  item_t sbQ[$];
  int    nCompared   = 0;
  int    nMismatched = 0;
  int    expStall    = 0;
  out_t  act;

  assign act = {fwd_rs, fwd_rt, pc_stall, ifid_stall, idex_bubble, pipe_freeze,
                ifid_flush, mem_timeout, stall_cnt};

  always @(negedge clk) begin
    item_t it;
    if (sbQ.size() > 0) begin
      it = sbQ.pop_front();
      nCompared++;
      if (act !== it.exp) begin
        nMismatched++;
        $display("FAIL %s: got %b required %b (fwdRs,fwdRt,pcSt,ifidSt,bubble,freeze,flush,timeout,cnt)",
                 it.name, act, it.exp);
      end
    end
  end

  task automatic idle();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_branch = 1'b0; id_taken = 1'b0;
    ex_wen = 1'b0; mem_wen = 1'b0; ex_waddr = '0; mem_waddr = '0;
    ex_is_load = 1'b0; mem_is_load = 1'b0; mem_access = 1'b0; MIO_ready = 1'b1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Expected stall_cnt is the number of earlier stalled cycles since reset, saturating.
  task automatic pushExp(input logic [1:0] fr, input logic [1:0] ft, input logic st,
                         input logic bub, input logic frz, input logic fl,
                         input logic to, input string nm);
    item_t it;
    if (!rst_n) expStall = 0;
    it.exp  = {fr, ft, st, st, bub, frz, fl, to, PERF_W'(expStall)};
    it.name = nm;
    sbQ.push_back(it);
    if (rst_n && st) expStall = (expStall == CNT_MAX) ? CNT_MAX : expStall + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle();

    nextCycle(); pushExp(2'd0, 2'd0, 0, 0, 0, 0, 0, "reset_idle");
    nextCycle(); id_taken = 1'b1;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 1, 0, "reset_comb_flush");

    nextCycle(); rst_n = 1'b1;
                 ex_wen = 1'b1; ex_waddr = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
                 pushExp(FWD ? 2'd1 : 2'd0, 2'd0, !FWD, !FWD, 0, 0, 0, "ex_alu_rs");
    nextCycle(); ex_wen = 1'b1; ex_waddr = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 0, 0, "zero_reg");
    nextCycle(); ex_wen = 1'b1; ex_waddr = 5'd7; id_rt = 5'd7; id_use_rt = 1'b0;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 0, 0, "use_off");
    nextCycle(); mem_wen = 1'b1; mem_waddr = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
                 pushExp(2'd0, FWD ? 2'd2 : 2'd0, !FWD, !FWD, 0, 0, 0, "mem_alu_rt");
    nextCycle(); ex_wen = 1'b1; ex_waddr = 5'd3; mem_wen = 1'b1; mem_waddr = 5'd3;
                 mem_is_load = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1;
                 pushExp(FWD ? 2'd1 : 2'd0, 2'd0, !FWD, !FWD, 0, 0, 0, "ex_over_mem");
    nextCycle(); ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd5; id_rt = 5'd5; id_use_rt = 1'b1;
                 pushExp(2'd0, 2'd0, 1, 1, 0, 0, 0, "load_use");
    nextCycle(); mem_wen = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd5; id_rt = 5'd5; id_use_rt = 1'b1;
                 pushExp(2'd0, FWD ? 2'd3 : 2'd0, !FWD, !FWD, 0, 0, 0, "mem_load_rt");
    nextCycle(); id_branch = 1'b1; ex_wen = 1'b1; ex_waddr = 5'd4; id_rs = 5'd4; id_use_rs = 1'b1;
                 pushExp(FWD ? 2'd1 : 2'd0, 2'd0, 1, 1, 0, 0, 0, "branch_ex");
    nextCycle(); id_taken = 1'b1; ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd6;
                 id_rs = 5'd6; id_use_rs = 1'b1;
                 pushExp(2'd0, 2'd0, 1, 1, 0, 0, 0, "flush_held");
    nextCycle(); id_taken = 1'b1; mem_wen = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd6;
                 id_rs = 5'd6; id_use_rs = 1'b1;
                 pushExp(FWD ? 2'd3 : 2'd0, 2'd0, !FWD, !FWD, 0, FWD, 0, "flush_after_stall");
    nextCycle(); id_taken = 1'b1;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 1, 0, "flush_clean");

    nextCycle(); rst_n = 1'b0;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 0, 0, "async_reset");
    nextCycle(); rst_n = 1'b1;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 0, 0, "reset_release");

    // Three busy cycles then ready: exactly three frozen cycles, stall_cnt reaches 3.
    nextCycle(); mem_access = 1'b1; MIO_ready = 1'b0; id_taken = 1'b1;
                 ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd6; id_rs = 5'd6; id_use_rs = 1'b1;
                 pushExp(2'd0, 2'd0, 1, 0, 1, 0, 0, "freeze_entry");
    for (int i = 0; i < 2; i++) begin
      nextCycle(); mem_access = 1'b1; MIO_ready = 1'b0;
                   pushExp(2'd0, 2'd0, 1, 0, 1, 0, 0, "freeze_wait");
    end
    nextCycle(); mem_access = 1'b1;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 0, 0, "wait_done");
    nextCycle(); MIO_ready = 1'b0;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 0, 0, "back_in_run");

    nextCycle(); mem_access = 1'b1; MIO_ready = 1'b0;
                 pushExp(2'd0, 2'd0, 1, 0, 1, 0, 0, "mwait_enter");
    nextCycle(); MIO_ready = 1'b0;
                 pushExp(2'd0, 2'd0, 1, 0, 1, 0, 0, "mwait_hold");
    nextCycle(); rst_n = 1'b0; MIO_ready = 1'b0;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 0, 0, "reset_mid_wait");
    nextCycle(); rst_n = 1'b1; MIO_ready = 1'b0;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 0, 0, "run_after_reset");

    // One RUN cycle plus WAIT_TO+1 MWAIT cycles precede FAULT.
    for (int i = 0; i < WAIT_TO + 2; i++) begin
      nextCycle(); mem_access = 1'b1; MIO_ready = 1'b0;
                   pushExp(2'd0, 2'd0, 1, 0, 1, 0, 0, "pre_timeout");
    end
    for (int i = 0; i < 3; i++) begin
      nextCycle(); id_taken = 1'b1; ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd6;
                   id_rs = 5'd6; id_use_rs = 1'b1;
                   pushExp(2'd0, 2'd0, 1, 0, 1, 0, 1, "fault_sticky");
    end
    nextCycle(); rst_n = 1'b0;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 0, 0, "fault_cleared");
    nextCycle(); rst_n = 1'b1;
                 pushExp(2'd0, 2'd0, 0, 0, 0, 0, 0, "post_fault");

    nextCycle();
    @(negedge clk);
    #1;
    if (sbQ.size() != 0) begin
      nMismatched++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
